// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with return-address stack
// Next PC selection for sequential, branch, jump, call and return flows.
module pc_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int OFFSET_WIDTH = 8,
  parameter int RAS_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                                 Clk,
  input  logic                                 Clear,
  input  logic                                 Stall,
  input  logic                                 Branch_Taken,
  input  logic                                 Jump,
  input  logic                                 Call,
  input  logic                                 Return,
  input  logic [OFFSET_WIDTH-1:0]              Offset,
  input  logic [ADDR_WIDTH-1:0]                Jump_Target,
  output logic [ADDR_WIDTH-1:0]                PC,
  output logic [ADDR_WIDTH-1:0]                Next_PC,
  output logic [$clog2(RAS_DEPTH+1)-1:0]       Stack_Depth,
  output logic                                 Stack_Overflow,
  output logic                                 Stack_Underflow
);

  localparam int DW = $clog2(RAS_DEPTH + 1);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [DW-1:0] DEPTH_FULL = DW'(RAS_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(RAS_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]         top;
  logic [PW-1:0]         top_inc;
  logic [PW-1:0]         top_dec;

  logic signed [OFFSET_WIDTH-1:0] offset_s;
  logic [ADDR_WIDTH-1:0]          offset_ext;
  logic [ADDR_WIDTH-1:0]          seq_pc;
  logic [ADDR_WIDTH-1:0]          branch_pc;
  logic                           stack_empty;
  logic                           do_pop;
  logic                           do_push;

  // Pointer arithmetic wraps explicitly so non-power-of-two depths stay circular.
  always_comb begin
    top_inc = (top == PTR_LAST) ? '0 : top + PW'(1);
    top_dec = (top == '0) ? PTR_LAST : top - PW'(1);
  end

  always_comb begin
    offset_s    = Offset;
    offset_ext  = ADDR_WIDTH'(offset_s);
    seq_pc      = PC + ADDR_WIDTH'(1);
    branch_pc   = seq_pc + offset_ext;
    stack_empty = (Stack_Depth == '0);
    do_pop      = !Stall && Return;
    do_push     = !Stall && Call && !Return;
  end

  always_comb begin
    Next_PC = seq_pc;
    if (Stall)
      Next_PC = PC;
    else if (Return)
      Next_PC = stack_empty ? seq_pc : ras[top];
    else if (Call || Jump)
      Next_PC = Jump_Target;
    else if (Branch_Taken)
      Next_PC = branch_pc;
  end

  always_ff @(posedge Clk) begin
    if (Clear) begin
      PC              <= RESET_PC;
      Stack_Depth     <= '0;
      Stack_Overflow  <= 1'b0;
      Stack_Underflow <= 1'b0;
      top             <= '0;
    end else if (!Stall) begin
      PC <= Next_PC;
      if (do_pop) begin
        if (stack_empty) begin
          Stack_Underflow <= 1'b1;
        end else begin
          Stack_Depth <= Stack_Depth - DW'(1);
          top         <= top_dec;
        end
      end else if (do_push) begin
        top <= top_inc;
        // A push onto a full stack overwrites the oldest slot; depth saturates.
        if (Stack_Depth == DEPTH_FULL)
          Stack_Overflow <= 1'b1;
        else
          Stack_Depth <= Stack_Depth + DW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clear && do_push)
      ras[top_inc] <= seq_pc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic       Clk;
  logic       Clear;
  logic       Stall;
  logic       Branch_Taken;
  logic       Jump;
  logic       Call;
  logic       Return;
  logic [7:0] Offset;
  logic [7:0] Jump_Target;
  logic [7:0] PC;
  logic [7:0] Next_PC;
  logic [2:0] Stack_Depth;
  logic       Stack_Overflow;
  logic       Stack_Underflow;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(
    .ADDR_WIDTH(8),
    .OFFSET_WIDTH(8),
    .RAS_DEPTH(4),
    .RESET_PC(8'h00)
  ) dut (
    .Clk(Clk),
    .Clear(Clear),
    .Stall(Stall),
    .Branch_Taken(Branch_Taken),
    .Jump(Jump),
    .Call(Call),
    .Return(Return),
    .Offset(Offset),
    .Jump_Target(Jump_Target),
    .PC(PC),
    .Next_PC(Next_PC),
    .Stack_Depth(Stack_Depth),
    .Stack_Overflow(Stack_Overflow),
    .Stack_Underflow(Stack_Underflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Clear = 0; Stall = 0; Branch_Taken = 0; Jump = 0; Call = 0; Return = 0;
    Offset = 8'h00; Jump_Target = 8'h00;
  endtask

  task automatic do_clear();
    idle_inputs();
    Clear = 1;
    tick();
    Clear = 0;
  endtask

  task automatic do_jump(input logic [7:0] tgt);
    Jump = 1; Jump_Target = tgt;
    tick();
    Jump = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Clear = 1;
    tick();
    tick();
    Clear = 0;
    checks++;
    if (PC !== 8'h00 || Stack_Depth !== 3'd0 || Stack_Overflow !== 1'b0 || Stack_Underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: pc=%h depth=%0d ov=%b un=%b, expected pc=00 depth=0 ov=0 un=0",
               PC, Stack_Depth, Stack_Overflow, Stack_Underflow);
    end
  endtask

  task automatic test_idle_wrap();
    do_clear();
    for (int i = 0; i < 260; i++) begin
      checks++;
      if (PC !== 8'(i) || Next_PC !== 8'(i + 1)) begin
        errors++;
        $display("FAIL idle[%0d]: pc=%h next=%h, expected pc=%h next=%h",
                 i, PC, Next_PC, 8'(i), 8'(i + 1));
      end
      tick();
    end
    checks++;
    if (PC !== 8'h04 || Stack_Overflow !== 1'b0 || Stack_Underflow !== 1'b0) begin
      errors++;
      $display("FAIL idle_end: pc=%h ov=%b un=%b, expected pc=04 ov=0 un=0",
               PC, Stack_Overflow, Stack_Underflow);
    end
  endtask

  task automatic test_branch();
    do_jump(8'h10);
    Branch_Taken = 1; Offset = 8'hFE;
    #1;
    checks++;
    if (Next_PC !== 8'h0F) begin
      errors++;
      $display("FAIL branch_next: next=%h, expected 0f", Next_PC);
    end
    tick();
    checks++;
    if (PC !== 8'h0F) begin
      errors++;
      $display("FAIL branch_back: pc=%h, expected 0f", PC);
    end
    Offset = 8'h05;
    tick();
    checks++;
    if (PC !== 8'h15) begin
      errors++;
      $display("FAIL branch_fwd: pc=%h, expected 15", PC);
    end
    Branch_Taken = 0;
    do_jump(8'hFE);
    Branch_Taken = 1; Offset = 8'h03;
    tick();
    Branch_Taken = 0;
    checks++;
    if (PC !== 8'h02) begin
      errors++;
      $display("FAIL branch_wrap: pc=%h, expected 02", PC);
    end
  endtask

  task automatic test_call_return();
    do_jump(8'h20);
    Call = 1; Jump_Target = 8'h80;
    tick();
    Call = 0;
    checks++;
    if (PC !== 8'h80 || Stack_Depth !== 3'd1) begin
      errors++;
      $display("FAIL call: pc=%h depth=%0d, expected pc=80 depth=1", PC, Stack_Depth);
    end
    Return = 1;
    #1;
    checks++;
    if (Next_PC !== 8'h21) begin
      errors++;
      $display("FAIL return_next: next=%h, expected 21", Next_PC);
    end
    tick();
    Return = 0;
    checks++;
    if (PC !== 8'h21 || Stack_Depth !== 3'd0) begin
      errors++;
      $display("FAIL return: pc=%h depth=%0d, expected pc=21 depth=0", PC, Stack_Depth);
    end
  endtask

  task automatic test_overflow_underflow();
    logic [7:0] targets [5];
    logic [7:0] rets [4];
    targets = '{8'h30, 8'h50, 8'h70, 8'h90, 8'hB0};
    rets = '{8'h91, 8'h71, 8'h51, 8'h31};
    do_jump(8'h10);
    for (int k = 0; k < 5; k++) begin
      Call = 1; Jump_Target = targets[k];
      tick();
      Call = 0;
      checks++;
      if (PC !== targets[k] || Stack_Depth !== 3'((k < 4) ? k + 1 : 4) ||
          Stack_Overflow !== (k == 4)) begin
        errors++;
        $display("FAIL nest_call[%0d]: pc=%h depth=%0d ov=%b, expected pc=%h depth=%0d ov=%b",
                 k, PC, Stack_Depth, Stack_Overflow, targets[k], (k < 4) ? k + 1 : 4, k == 4);
      end
    end
    for (int k = 0; k < 4; k++) begin
      Return = 1;
      tick();
      Return = 0;
      checks++;
      if (PC !== rets[k] || Stack_Depth !== 3'(3 - k)) begin
        errors++;
        $display("FAIL nest_ret[%0d]: pc=%h depth=%0d, expected pc=%h depth=%0d",
                 k, PC, Stack_Depth, rets[k], 3 - k);
      end
    end
    Return = 1;
    tick();
    Return = 0;
    checks++;
    if (PC !== 8'h32 || Stack_Depth !== 3'd0 || Stack_Underflow !== 1'b1 || Stack_Overflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow: pc=%h depth=%0d un=%b ov=%b, expected pc=32 depth=0 un=1 ov=1",
               PC, Stack_Depth, Stack_Underflow, Stack_Overflow);
    end
  endtask

  task automatic test_stall();
    Stall = 1; Branch_Taken = 1; Call = 1; Return = 1; Offset = 8'h10; Jump_Target = 8'hCC;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (Next_PC !== 8'h32) begin
        errors++;
        $display("FAIL stall_next[%0d]: next=%h, expected 32", k, Next_PC);
      end
      tick();
      checks++;
      if (PC !== 8'h32 || Stack_Depth !== 3'd0 || Stack_Overflow !== 1'b1 || Stack_Underflow !== 1'b1) begin
        errors++;
        $display("FAIL stall[%0d]: pc=%h depth=%0d ov=%b un=%b, expected pc=32 depth=0 ov=1 un=1",
                 k, PC, Stack_Depth, Stack_Overflow, Stack_Underflow);
      end
    end
    idle_inputs();
    do_jump(8'h44);
    checks++;
    if (PC !== 8'h44) begin
      errors++;
      $display("FAIL stall_release: pc=%h, expected 44", PC);
    end
  endtask

  task automatic test_priority();
    do_clear();
    do_jump(8'h40);
    Call = 1; Jump_Target = 8'h60;
    tick();
    Call = 1; Return = 1; Jump = 1; Branch_Taken = 1; Jump_Target = 8'hAA; Offset = 8'h07;
    tick();
    idle_inputs();
    checks++;
    if (PC !== 8'h41 || Stack_Depth !== 3'd0 || Stack_Overflow !== 1'b0) begin
      errors++;
      $display("FAIL prio_return: pc=%h depth=%0d ov=%b, expected pc=41 depth=0 ov=0",
               PC, Stack_Depth, Stack_Overflow);
    end
    Jump = 1; Branch_Taken = 1; Jump_Target = 8'h12; Offset = 8'h05;
    tick();
    idle_inputs();
    checks++;
    if (PC !== 8'h12 || Stack_Depth !== 3'd0) begin
      errors++;
      $display("FAIL prio_jump: pc=%h depth=%0d, expected pc=12 depth=0", PC, Stack_Depth);
    end
  endtask

  task automatic test_clear_midstream();
    do_clear();
    for (int k = 0; k < 5; k++) begin
      Call = 1; Jump_Target = 8'(8'h20 * (k + 1));
      tick();
    end
    Call = 0;
    Return = 1;
    tick();
    Return = 0;
    checks++;
    if (Stack_Depth !== 3'd3 || Stack_Overflow !== 1'b1) begin
      errors++;
      $display("FAIL pre_clear: depth=%0d ov=%b, expected depth=3 ov=1", Stack_Depth, Stack_Overflow);
    end
    Clear = 1; Call = 1; Jump_Target = 8'h99;
    tick();
    Clear = 0; Call = 0;
    checks++;
    if (PC !== 8'h00 || Stack_Depth !== 3'd0 || Stack_Overflow !== 1'b0 || Stack_Underflow !== 1'b0) begin
      errors++;
      $display("FAIL clear_call: pc=%h depth=%0d ov=%b un=%b, expected pc=00 depth=0 ov=0 un=0",
               PC, Stack_Depth, Stack_Overflow, Stack_Underflow);
    end
    Return = 1;
    tick();
    Return = 0;
    checks++;
    if (PC !== 8'h01 || Stack_Depth !== 3'd0 || Stack_Underflow !== 1'b1) begin
      errors++;
      $display("FAIL clear_return: pc=%h depth=%0d un=%b, expected pc=01 depth=0 un=1",
               PC, Stack_Depth, Stack_Underflow);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_idle_wrap();
    test_branch();
    test_call_return();
    test_overflow_underflow();
    test_stall();
    test_priority();
    test_clear_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
